dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port: accepts load/store requests over a valid/ready handshake and returns load data with a programmable number of wait states.
- Performs RISC-V sized accesses (byte/half/word, signed/unsigned) with little-endian byte lanes.
- Flags illegal accesses on a response error bit.
- Replaces the zero-latency data array when the core is moved to a multi-cycle memory interface.

---
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Purpose: data-memory responder; sized RISC-V loads/stores on a word array, error flag on illegal access.
// Latency: resp_valid rises LATENCY+1 cycles after the accept cycle; one request outstanding at a time.
// Backpressure: response held stable while resp_ready=0; req_ready stays low until the response is taken.
// Optional: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WIDX_W = ADDR_WIDTH - 2;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic accept, commit, resp_done;

    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [2:0]            lat_f3;
    logic [31:0]           lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    // The access being committed: straight from the request port when LATENCY=0
    // commits on the accept edge, otherwise from the latched copy.
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [2:0]            acc_f3;
    logic [31:0]           acc_wdata;

    assign acc_we    = (state == IDLE) ? req_we     : lat_we;
    assign acc_addr  = (state == IDLE) ? req_addr   : lat_addr;
    assign acc_f3    = (state == IDLE) ? req_funct3 : lat_f3;
    assign acc_wdata = (state == IDLE) ? req_wdata  : lat_wdata;

    logic [WIDX_W-1:0] widx;
    logic [IDX_W-1:0]  mem_idx;
    logic [1:0]        lane;
    logic              range_err, f3_err, align_err, acc_err;
    logic [31:0]       rd_word, wr_word, load_val;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              mem_we;

    assign widx      = acc_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = widx[IDX_W-1:0];
    assign range_err = (widx >= WIDX_W'(DEPTH_WORDS));
    assign f3_err    = acc_we ? (acc_f3 > 3'b010)
                              : ((acc_f3 == 3'b011) || (acc_f3[2:1] == 2'b11));
    assign acc_err   = range_err || f3_err || align_err;
    assign rd_word   = range_err ? 32'd0 : mem[mem_idx];
    assign mem_we    = commit && acc_we && !acc_err && !rst;

    // Byte lane selection; misaligned half/word either trap or drop the low address bits.
    always_comb begin
        lane      = acc_addr[1:0];
        align_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (acc_f3[1:0] == 2'b01)
            align_err = lane[0];
        else if (acc_f3[1:0] == 2'b10)
            align_err = (lane != 2'b00);
`else
        if (acc_f3[1:0] == 2'b01)
            lane[0] = 1'b0;
        else if (acc_f3[1:0] == 2'b10)
            lane = 2'b00;
`endif
    end

    // Load extraction with sign/zero extension, and store merge into the existing word.
    always_comb begin
        byte_v   = rd_word[{lane, 3'b000} +: 8];
        half_v   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        wr_word  = rd_word;
        case (acc_f3[1:0])
            2'b00: begin
                load_val = acc_f3[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
                wr_word[{lane, 3'b000} +: 8] = acc_wdata[7:0];
            end
            2'b01: begin
                load_val = acc_f3[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
                if (lane[1])
                    wr_word[31:16] = acc_wdata[15:0];
                else
                    wr_word[15:0] = acc_wdata[15:0];
            end
            default: begin
                load_val = rd_word;
                wr_word  = acc_wdata;
            end
        endcase
    end

    // Next-state, wait counter and handshake outputs.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        resp_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        commit    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = LAT_M1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    resp_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request on the accept edge; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_f3    <= 3'd0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_f3    <= req_funct3;
            lat_wdata <= req_wdata;
        end
    end

    // Response data/error registered on the commit edge, held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_rdata <= (acc_we || acc_err) ? 32'd0 : load_val;
            resp_err   <= acc_err;
        end else if (resp_done) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end
    end

    // Array write on the commit edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_idx] <= wr_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 runs LATENCY=1, instance 1 runs LATENCY=4.
// Expected responses are queued when a request is issued and compared when the response appears.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       req_valid, req_ready, req_we;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0][2:0]  req_funct3;
    logic [1:0]       resp_valid, resp_ready, resp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .ADDR_WIDTH(32)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .ADDR_WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check latency, then compare the response against the queue head.
    task automatic do_req(input int s, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int hold, input string tag);
        exp_t e;
        int   n;
        int   lat_exp;
        lat_exp = (s == 0) ? 2 : 5;
        e.rdata = exp_rd;
        e.err   = exp_err;
        exp_q.push_back(e);
        req_valid[s]  = 1'b1;
        req_we[s]     = we;
        req_addr[s]   = addr;
        req_funct3[s] = f3;
        req_wdata[s]  = wd;
        n = 0;
        while (!req_ready[s] && n < 20) begin
            tick();
            n++;
        end
        check({tag, "/ready"}, 32'(req_ready[s]), 32'd1);
        tick();
        // Scramble inputs after accept: the responder must use the latched copy.
        req_valid[s]  = 1'b0;
        req_we[s]     = 1'($urandom);
        req_addr[s]   = $urandom;
        req_funct3[s] = 3'($urandom);
        req_wdata[s]  = $urandom;
        n = 1;
        while (!resp_valid[s] && n < 40) begin
            tick();
            n++;
        end
        check({tag, "/lat"}, 32'(n), 32'(lat_exp));
        e = exp_q.pop_front();
        if (resp_valid[s]) begin
            check({tag, "/rdata"}, resp_rdata[s], e.rdata);
            check({tag, "/err"}, 32'(resp_err[s]), 32'(e.err));
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, "/bp_valid"}, 32'(resp_valid[s]), 32'd1);
                check({tag, "/bp_rdata"}, resp_rdata[s], e.rdata);
                check({tag, "/bp_rdy"}, 32'(req_ready[s]), 32'd0);
            end
            resp_ready[s] = 1'b1;
            tick();
            resp_ready[s] = 1'b0;
            check({tag, "/vld_drop"}, 32'(resp_valid[s]), 32'd0);
            check({tag, "/rdy_back"}, 32'(req_ready[s]), 32'd1);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lane +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] model_w;
        logic [31:0] rnd_a;
        logic [2:0]  rnd_f3;
        logic [1:0]  rnd_lane;
        logic        seen;
        int          widx;

        rst        = 2'b00;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_funct3 = '0;
        req_wdata  = '0;
        resp_ready = '0;
        #1;
        rst = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_ready0", 32'(req_ready[0]), 32'd0);
            check("rst_req_ready1", 32'(req_ready[1]), 32'd0);
        end
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp_rdata", resp_rdata[0], 32'd0);
        check("rst_resp_err", 32'(resp_err[0]), 32'd0);
        rst = 2'b00;
        #1;
        check("post_rst_ready0", 32'(req_ready[0]), 32'd1);
        check("post_rst_ready1", 32'(req_ready[1]), 32'd1);

        // Basic store then load
        do_req(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw_10");
        do_req(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw_10");

        // Sized loads
        do_req(0, 1'b1, 32'h08, 3'b010, 32'h80FF7F01, 32'h0, 1'b0, 0, "sw_08");
        do_req(0, 1'b0, 32'h08, 3'b000, 32'h0, 32'h00000001, 1'b0, 0, "lb_08");
        do_req(0, 1'b0, 32'h0A, 3'b000, 32'h0, 32'hFFFFFFFF, 1'b0, 0, "lb_0a");
        do_req(0, 1'b0, 32'h0A, 3'b100, 32'h0, 32'h000000FF, 1'b0, 0, "lbu_0a");
        do_req(0, 1'b0, 32'h0A, 3'b001, 32'h0, 32'hFFFF80FF, 1'b0, 0, "lh_0a");
        do_req(0, 1'b0, 32'h0A, 3'b101, 32'h0, 32'h000080FF, 1'b0, 0, "lhu_0a");
        do_req(0, 1'b0, 32'h0B, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, 0, "lb_0b");
        do_req(0, 1'b0, 32'h08, 3'b001, 32'h0, 32'h00007F01, 1'b0, 0, "lh_08");

        // Byte/half stores
        do_req(0, 1'b1, 32'h20, 3'b010, 32'h11223344, 32'h0, 1'b0, 0, "sw_20");
        do_req(0, 1'b1, 32'h21, 3'b000, 32'h000000AB, 32'h0, 1'b0, 0, "sb_21");
        do_req(0, 1'b0, 32'h20, 3'b010, 32'h0, 32'h1122AB44, 1'b0, 0, "lw_20a");
        do_req(0, 1'b1, 32'h22, 3'b001, 32'h0000CDEF, 32'h0, 1'b0, 0, "sh_22");
        do_req(0, 1'b0, 32'h20, 3'b010, 32'h0, 32'hCDEFAB44, 1'b0, 0, "lw_20b");

        // Backpressure: hold resp_ready low for 5 cycles
        do_req(0, 1'b0, 32'h20, 3'b010, 32'h0, 32'hCDEFAB44, 1'b0, 5, "bp_lw_20");

        // Errors
        do_req(0, 1'b0, 32'(DEPTH * 4), 3'b010, 32'h0, 32'h0, 1'b1, 0, "lw_oor");
        do_req(0, 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 0, "ld_f3_011");
        do_req(0, 1'b0, 32'h10, 3'b110, 32'h0, 32'h0, 1'b1, 0, "ld_f3_110");
        do_req(0, 1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "st_f3_011");
        do_req(0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw_10_kept");
        do_req(0, 1'b1, 32'h00, 3'b010, 32'hA5A5A5A5, 32'h0, 1'b0, 0, "sw_00");
        do_req(0, 1'b1, 32'(DEPTH * 4 - 4), 3'b010, 32'h12345678, 32'h0, 1'b0, 0, "sw_last");
        do_req(0, 1'b1, 32'(DEPTH * 4), 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "sw_oor");
        do_req(0, 1'b0, 32'(DEPTH * 4 - 4), 3'b010, 32'h0, 32'h12345678, 1'b0, 0, "lw_last");
        do_req(0, 1'b0, 32'h00, 3'b010, 32'h0, 32'hA5A5A5A5, 1'b0, 0, "lw_00_kept");

        // Misalignment
        do_req(0, 1'b1, 32'h28, 3'b010, 32'h01010101, 32'h0, 1'b0, 0, "sw_28");
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(0, 1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1, 0, "lw_12_mis");
        do_req(0, 1'b0, 32'h13, 3'b001, 32'h0, 32'h0, 1'b1, 0, "lh_13_mis");
        do_req(0, 1'b1, 32'h2B, 3'b010, 32'hCAFEF00D, 32'h0, 1'b1, 0, "sw_2b_mis");
        do_req(0, 1'b1, 32'h29, 3'b001, 32'h00001234, 32'h0, 1'b1, 0, "sh_29_mis");
        do_req(0, 1'b0, 32'h28, 3'b010, 32'h0, 32'h01010101, 1'b0, 0, "lw_28_kept");
`else
        do_req(0, 1'b0, 32'h12, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw_12_algn");
        do_req(0, 1'b0, 32'h13, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0, 0, "lh_13_algn");
        do_req(0, 1'b1, 32'h2B, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 0, "sw_2b_algn");
        do_req(0, 1'b1, 32'h29, 3'b001, 32'h00001234, 32'h0, 1'b0, 0, "sh_29_algn");
        do_req(0, 1'b0, 32'h28, 3'b010, 32'h0, 32'hCAFE1234, 1'b0, 0, "lw_28_algn");
`endif

        // Random word stores followed by a random aligned sized load of the same word
        for (int i = 0; i < 12; i++) begin
            widx     = $urandom_range(64, 127);
            model_w  = $urandom;
            rnd_a    = 32'(widx * 4);
            do_req(0, 1'b1, rnd_a, 3'b010, model_w, 32'h0, 1'b0, 0, "rnd_sw");
            case ($urandom_range(0, 4))
                0:       rnd_f3 = 3'b000;
                1:       rnd_f3 = 3'b100;
                2:       rnd_f3 = 3'b001;
                3:       rnd_f3 = 3'b101;
                default: rnd_f3 = 3'b010;
            endcase
            rnd_lane = 2'($urandom);
            if (rnd_f3[1:0] == 2'b01) rnd_lane[0] = 1'b0;
            if (rnd_f3[1:0] == 2'b10) rnd_lane = 2'b00;
            do_req(0, 1'b0, rnd_a | 32'(rnd_lane), rnd_f3, 32'h0,
                   ld_model(model_w, rnd_f3, rnd_lane), 1'b0, 0, "rnd_ld");
        end

        // LATENCY=4 instance: normal store, then a store aborted by reset in WAIT
        do_req(1, 1'b1, 32'h30, 3'b010, 32'h00000077, 32'h0, 1'b0, 2, "b_sw_30");
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 32'h30;
        req_funct3[1] = 3'b010;
        req_wdata[1]  = 32'h5;
        check("b_abort_ready", 32'(req_ready[1]), 32'd1);
        tick();
        req_valid[1] = 1'b0;
        req_we[1]    = 1'b0;
        tick();
        tick();
        rst[1] = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            seen = seen | resp_valid[1];
            check("b_abort_rst_ready", 32'(req_ready[1]), 32'd0);
        end
        rst[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | resp_valid[1];
        end
        check("b_abort_no_resp", 32'(seen), 32'd0);
        do_req(1, 1'b0, 32'h30, 3'b010, 32'h0, 32'h00000077, 1'b0, 0, "b_lw_30");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
